// File: rtl/vga_frame_window.sv
// vga_frame_window: windowed, upscaled, double-buffered frame-buffer read address generator and pixel formatter
module vga_frame_window #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW = 17,
    parameter int DW = 8,
    parameter int SCREEN_X = 640,
    parameter int SCREEN_Y = 480,
    parameter logic [DW-1:0] BORDER_COLOR = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [8:0]    posY,
    input  logic [9:0]    org_x,
    input  logic [8:0]    org_y,
    input  logic [1:0]    scale,
    input  logic          bank_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] pixel_out,
    output logic          bank_cur,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);
    localparam logic [AW-1:0] BANK_SIZE = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);
    localparam logic [AW-1:0] ROW = AW'(CAM_SCREEN_X);
    localparam logic [11:0] CX = 12'(CAM_SCREEN_X);
    localparam logic [11:0] CY = 12'(CAM_SCREEN_Y);
    localparam logic [11:0] SX = 12'(SCREEN_X);
    localparam logic [11:0] SY = 12'(SCREEN_Y);

    logic [9:0]    org_x_q;
    logic [8:0]    org_y_q;
    logic [1:0]    scale_q;
    logic          bank_q;
    logic          zero_q;
    logic          frame_start_q;
    logic [7:0]    frame_cnt_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] mem_addr_d;
    logic [1:0]    win_q;
    logic [DW-1:0] pixel_q;

    logic          at_zero;
    logic          fs;
    logic [9:0]    ox;
    logic [8:0]    oy;
    logic [1:0]    sc;
    logic [1:0]    s;
    logic          bk;
    logic [11:0]   px;
    logic [11:0]   py;
    logic [11:0]   rel_x;
    logic [11:0]   rel_y;
    logic          in_win;
    logic [AW-1:0] base;

    // Window test and address; on a frame start the fresh inputs apply to the (0,0) sample itself
    always_comb begin
        at_zero = posX == 10'd0 && posY == 9'd0;
        fs = at_zero && !zero_q;
        ox = fs ? org_x : org_x_q;
        oy = fs ? org_y : org_y_q;
        sc = fs ? scale : scale_q;
        bk = fs ? bank_req : bank_q;
        s = (sc == 2'd3) ? 2'd2 : sc;
        px = {2'b00, posX};
        py = {3'b000, posY};
        rel_x = px - {2'b00, ox};
        rel_y = py - {3'b000, oy};
        in_win = px >= {2'b00, ox} && py >= {3'b000, oy} && rel_x < (CX << s) && rel_y < (CY << s)
                 && px < SX && py < SY;
        base = bk ? BANK_SIZE : '0;
        mem_addr_d = in_win ? base + AW'(rel_y >> s) * ROW + AW'(rel_x >> s) : base;
    end

    // Shadow loading, frame counting, and the address/in-window/pixel pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            org_x_q       <= '0;
            org_y_q       <= '0;
            scale_q       <= '0;
            bank_q        <= 1'b0;
            zero_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            mem_addr_q    <= '0;
            win_q         <= '0;
            pixel_q       <= '0;
        end else begin
            zero_q        <= at_zero;
            frame_start_q <= fs;
            if (fs) begin
                org_x_q     <= org_x;
                org_y_q     <= org_y;
                scale_q     <= scale;
                bank_q      <= bank_req;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            mem_addr_q <= mem_addr_d;
            win_q      <= {win_q[0], in_win};
            pixel_q    <= win_q[1] ? mem_data : BORDER_COLOR;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign pixel_out   = pixel_q;
    assign bank_cur    = bank_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_frame_window.sv
// tb_vga_frame_window: directed vectors plus a per-cycle arithmetic model of window, scale, bank and latency
module tb_vga_frame_window;
    localparam int BS = 19200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  posX = '0;
    logic [8:0]  posY = '0;
    logic [9:0]  org_x = '0;
    logic [8:0]  org_y = '0;
    logic [1:0]  scale = '0;
    logic        bank_req = 1'b0;
    logic [16:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic [7:0]  pixel_out;
    logic        bank_cur;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    vga_frame_window dut (
        .clk(clk), .rst(rst), .posX(posX), .posY(posY), .org_x(org_x), .org_y(org_y),
        .scale(scale), .bank_req(bank_req), .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel_out(pixel_out), .bank_cur(bank_cur), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_f(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    // Synchronous RAM with one-cycle read latency
    always @(posedge clk) mem_data <= ram_f(int'(mem_addr));

    int m_ox, m_oy, m_sc, m_bank, m_cnt;
    bit m_prev0;
    int e_addr, e_pix, e_fs, e_bank, e_cnt;
    bit w0, w1;
    int a0, a1;

    // Reference model: window membership and address from plain integer arithmetic
    always @(posedge clk) begin : model
        int x, y, f, rx, ry;
        bit win, z, fs;
        x = int'(posX);
        y = int'(posY);
        if (rst) begin
            m_ox = 0; m_oy = 0; m_sc = 0; m_bank = 0; m_cnt = 0; m_prev0 = 0;
            e_addr = 0; e_pix = 0; e_fs = 0; e_bank = 0; e_cnt = 0;
            w0 = 0; w1 = 0; a0 = 0; a1 = 0;
            armed = 1'b1;
        end else begin
            z = (x == 0 && y == 0);
            fs = z && !m_prev0;
            m_prev0 = z;
            if (fs) begin
                m_ox = int'(org_x); m_oy = int'(org_y); m_sc = int'(scale); m_bank = int'(bank_req);
                m_cnt = (m_cnt + 1) % 256;
            end
            f = (m_sc == 0) ? 1 : (m_sc == 1) ? 2 : 4;
            rx = x - m_ox;
            ry = y - m_oy;
            win = rx >= 0 && ry >= 0 && rx < 160 * f && ry < 120 * f && x < 640 && y < 480;
            e_pix = w1 ? int'(ram_f(a1)) : 0;
            w1 = w0;
            a1 = a0;
            w0 = win;
            a0 = m_bank * BS + (win ? (ry / f) * 160 + rx / f : 0);
            e_addr = a0;
            e_fs = int'(fs);
            e_bank = m_bank;
            e_cnt = m_cnt;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle after reset: all outputs against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("model mem_addr", int'(mem_addr), e_addr);
            chk("model pixel_out", int'(pixel_out), e_pix);
            chk("model bank_cur", int'(bank_cur), e_bank);
            chk("model frame_start", int'(frame_start), e_fs);
            chk("model frame_cnt", int'(frame_cnt), e_cnt);
        end
    end

    task automatic step(input logic [9:0] x, input logic [8:0] y);
        posX = x;
        posY = y;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame();
        step(10'd1, 9'd0);
        step(10'd0, 9'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset pixel_out", int'(pixel_out), 0);
        chk("reset frame_cnt", int'(frame_cnt), 0);
        chk("reset bank_cur", int'(bank_cur), 0);
        chk("reset frame_start", int'(frame_start), 0);
        rst = 1'b0;
        step(10'd0, 9'd0);
        chk("first frame_start", int'(frame_start), 1);
        chk("first frame_cnt", int'(frame_cnt), 1);
        step(10'd5, 9'd2);
        chk("frame_start pulse width", int'(frame_start), 0);
        chk("x1 addr (5,2)", int'(mem_addr), 325);
        step(10'd6, 9'd2);
        step(10'd7, 9'd2);
        chk("x1 pixel (5,2)", int'(pixel_out), 230);
        step(10'd160, 9'd0);
        chk("x1 border addr", int'(mem_addr), 0);
        step(10'd161, 9'd0);
        step(10'd162, 9'd0);
        chk("x1 border pixel", int'(pixel_out), 0);
        step(10'd159, 9'd119);
        chk("x1 last pixel addr", int'(mem_addr), 19199);
        org_x = 10'd100; org_y = 9'd50; scale = 2'd1;
        frame();
        step(10'd103, 9'd55);
        chk("x2 addr (103,55)", int'(mem_addr), 321);
        step(10'd99, 9'd55);
        chk("x2 left border", int'(mem_addr), 0);
        step(10'd419, 9'd55);
        chk("x2 right edge", int'(mem_addr), 479);
        step(10'd420, 9'd55);
        chk("x2 past right", int'(mem_addr), 0);
        step(10'd100, 9'd289);
        chk("x2 bottom edge", int'(mem_addr), 19040);
        step(10'd100, 9'd290);
        chk("x2 past bottom", int'(mem_addr), 0);
        org_x = 10'd0; org_y = 9'd0; scale = 2'd2;
        frame();
        step(10'd639, 9'd479);
        chk("x4 corner", int'(mem_addr), 19199);
        scale = 2'd3;
        frame();
        step(10'd639, 9'd479);
        chk("scale3 corner", int'(mem_addr), 19199);
        scale = 2'd0;
        frame();
        step(10'd10, 9'd10);
        bank_req = 1'b1;
        step(10'd10, 9'd11);
        chk("bank held mid-frame", int'(bank_cur), 0);
        chk("bank0 addr", int'(mem_addr), 1770);
        frame();
        chk("bank switch frame_start", int'(frame_start), 1);
        chk("bank switch bank_cur", int'(bank_cur), 1);
        chk("bank1 origin addr", int'(mem_addr), 19200);
        step(10'd5, 9'd2);
        chk("bank1 addr (5,2)", int'(mem_addr), 19525);
        scale = 2'd2;
        frame();
        step(10'd300, 9'd240);
        chk("x4 bank1 addr", int'(mem_addr), 28875);
        org_x = 10'd200;
        step(10'd300, 9'd240);
        chk("origin held mid-frame", int'(mem_addr), 28875);
        frame();
        step(10'd300, 9'd240);
        chk("origin shifted", int'(mem_addr), 28825);
        step(10'd639, 9'd240);
        chk("clip last column", int'(mem_addr), 28909);
        step(10'd700, 9'd240);
        chk("clip off screen", int'(mem_addr), 19200);
        step(10'd199, 9'd240);
        chk("left of origin", int'(mem_addr), 19200);
        rst = 1'b1;
        step(10'd50, 9'd300);
        rst = 1'b0;
        chk("midreset mem_addr", int'(mem_addr), 0);
        chk("midreset pixel_out", int'(pixel_out), 0);
        chk("midreset frame_cnt", int'(frame_cnt), 0);
        chk("midreset bank_cur", int'(bank_cur), 0);
        step(10'd51, 9'd300);
        chk("after reset addr", int'(mem_addr), 0);
        step(10'd0, 9'd0);
        chk("reload frame_cnt", int'(frame_cnt), 1);
        chk("reload bank_cur", int'(bank_cur), 1);
        chk("reload origin addr", int'(mem_addr), 19200);
        step(10'd300, 9'd240);
        chk("resumed addr", int'(mem_addr), 28825);
        for (int i = 0; i < 254; i++) frame();
        chk("frame_cnt 255", int'(frame_cnt), 255);
        frame();
        chk("frame_cnt wrap", int'(frame_cnt), 0);
        chk("wrap frame_start", int'(frame_start), 1);
        step(10'd300, 9'd240);
        step(10'd301, 9'd240);
        step(10'd302, 9'd240);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
